// File: rtl/mc_control_unit_pkg.sv
// mc_control_unit_pkg
//   State codes, RV32I opcodes, datapath control encodings and the control
//   strobe bundle shared by the multi-cycle control unit and its decoder.
package mc_control_unit_pkg;

  // Control-unit state codes.
  typedef enum logic [2:0] {
    S_IF1 = 3'd0,
    S_IF2 = 3'd1,
    S_ID  = 3'd2,
    S_EX  = 3'd3,
    S_MEM = 3'd4,
    S_WB  = 3'd5
  } state_e;

  // RV32I major opcodes.
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  // alu_op classes.
  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

  // ALU operand selects.
  localparam logic       ALU_A_PC   = 1'b0;
  localparam logic       ALU_A_REG  = 1'b1;
  localparam logic [1:0] ALU_B_REG  = 2'd0;
  localparam logic [1:0] ALU_B_FOUR = 2'd1;
  localparam logic [1:0] ALU_B_IMM  = 2'd2;

  // Write-back select.
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MDR = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  // PC source and memory address select.
  localparam logic PC_SRC_PC4 = 1'b0;
  localparam logic PC_SRC_ALU = 1'b1;
  localparam logic IOD_PC     = 1'b0;
  localparam logic IOD_ALU    = 1'b1;

  // Every datapath/memory strobe driven by the control unit.
  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // States that wait on the memory: fetch, load data, and store in WB.
  function automatic logic is_mem_state(input state_e st, input logic [6:0] op);
    return (st == S_IF2) || (st == S_MEM) || ((st == S_WB) && (op == OP_STORE));
  endfunction

endpackage

// File: rtl/mc_control_unit_decode.sv
// mc_ctrl_decode
//   Purely combinational strobe decode from the registered state and the
//   current opcode.
//   Inputs : state, opcode, bcond (valid in EX), mem_ready, halt_req
//   Output : ctrl (all datapath/memory strobes; unlisted strobes are 0)
module mc_ctrl_decode
  import mc_control_unit_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       mem_ready,
  input  logic       halt_req,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_IF1: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = IOD_PC;
      end
      S_IF2: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.alu_src_a = ALU_A_PC;
        ctrl.alu_src_b = ALU_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        // A non-halting ECALL retires here by stepping PC to PC+4.
        if ((opcode == OP_ECALL) && !halt_req) begin
          ctrl.pc_write  = mem_ready;
          ctrl.pc_source = PC_SRC_PC4;
        end
      end
      S_ID: begin
        // Branch/JAL target precomputed into ALUOut.
        ctrl.alu_src_a = ALU_A_PC;
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_EX: begin
        case (opcode)
          OP_ARITH: begin
            ctrl.alu_src_a = ALU_A_REG;
            ctrl.alu_src_b = ALU_B_REG;
            ctrl.alu_op    = ALU_OP_FUNCT;
          end
          OP_ARITH_IMM: begin
            ctrl.alu_src_a = ALU_A_REG;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_FUNCT;
          end
          OP_LOAD, OP_STORE, OP_JALR: begin
            ctrl.alu_src_a = ALU_A_REG;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
          end
          OP_JAL: begin
            ctrl.alu_src_a = ALU_A_PC;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
          end
          OP_BRANCH: begin
            ctrl.alu_src_a = ALU_A_REG;
            ctrl.alu_src_b = ALU_B_REG;
            ctrl.alu_op    = ALU_OP_BRANCH;
            // Not taken: retire now with PC+4; ALUOut keeps the target.
            if (!bcond) begin
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = PC_SRC_PC4;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = IOD_ALU;
      end
      S_WB: begin
        // A stalled store only commits the PC in its completing cycle.
        ctrl.pc_write  = (opcode == OP_STORE) ? mem_ready : 1'b1;
        ctrl.pc_source = ((opcode == OP_BRANCH) || (opcode == OP_JAL) ||
                          (opcode == OP_JALR)) ? PC_SRC_ALU : PC_SRC_PC4;
        case (opcode)
          OP_ARITH, OP_ARITH_IMM: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_SEL_ALU;
          end
          OP_LOAD: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_SEL_MDR;
          end
          OP_JAL, OP_JALR: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_SEL_PC4;
          end
          OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = IOD_ALU;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit
//   Multi-cycle RV32I control unit: state register fed by the external fsm
//   next-state block, memory stall, sticky ECALL halt, cycle and retired-
//   instruction counters, and the strobe decode (mc_ctrl_decode).
//   Inputs : clk, reset_n (async, active low), opcode, next_state, bcond,
//            halt_req, mem_ready
//   Outputs: current_state (also the debug view of the FSM), datapath and
//            memory strobes, is_halted, cycle_cnt, instret_cnt
//
//   Memory handshake: in a memory-access state (IF2, MEM, WB of a STORE) the
//   request is the asserted memory strobe; the access completes in the cycle
//   mem_ready = 1. Until then the state holds and the strobes stay asserted.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       next_state,
  input  logic             bcond,
  input  logic             halt_req,
  input  logic             mem_ready,
  output logic [2:0]       current_state,
  output logic             pc_write,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e           state_q, state_d;
  logic             halted_q;
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             stalled, halt_now, retire;
  ctrl_t            ctrl_raw, ctrl_out;

  assign stalled  = is_mem_state(state_q, opcode) && !mem_ready;
  assign halt_now = (state_q == S_IF2) && (opcode == OP_ECALL) && halt_req && mem_ready;

  // Next state: halt forces IF1 ahead of the fsm; a stall holds the state.
  always_comb begin
    state_d = state_q;
    if (halt_now) begin
      state_d = S_IF1;
    end else if (!stalled) begin
      state_d = state_e'(next_state);
    end
  end

  // An instruction retires on the edge that returns to IF1 from a state that
  // can end one (IF2 for ECALL, EX for branch-not-taken, MEM, WB).
  assign retire = (state_d == S_IF1) &&
                  ((state_q == S_IF2) || (state_q == S_EX) ||
                   (state_q == S_MEM) || (state_q == S_WB));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IF1;
      halted_q  <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (!halted_q) begin
      state_q  <= state_d;
      halted_q <= halt_now;
      cycle_q  <= cycle_q + CNT_W'(1);
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .bcond     (bcond),
    .mem_ready (mem_ready),
    .halt_req  (halt_req),
    .ctrl      (ctrl_raw)
  );

  // Strobes are silenced while reset is asserted and after a halt.
  assign ctrl_out = (reset_n && !halted_q) ? ctrl_raw : '0;

  assign current_state = state_q;
  assign is_halted     = halted_q;
  assign cycle_cnt     = cycle_q;
  assign instret_cnt   = instret_q;

  assign pc_write  = ctrl_out.pc_write;
  assign pc_source = ctrl_out.pc_source;
  assign i_or_d    = ctrl_out.i_or_d;
  assign mem_read  = ctrl_out.mem_read;
  assign mem_write = ctrl_out.mem_write;
  assign ir_write  = ctrl_out.ir_write;
  assign reg_write = ctrl_out.reg_write;
  assign wb_sel    = ctrl_out.wb_sel;
  assign alu_src_a = ctrl_out.alu_src_a;
  assign alu_src_b = ctrl_out.alu_src_b;
  assign alu_op    = ctrl_out.alu_op;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit
//   Randomized bench for mc_control_unit with a behavioural model of the
//   instruction flow, strobe rules, counters and per-instruction latency.
//   A second instance with CNT_W = 4 shares the stimulus to exercise wrap.
module tb_mc_control_unit;
  import mc_control_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] opcode = '0;
  logic [2:0] next_state = '0;
  logic       bcond = 1'b0, halt_req = 1'b0, mem_ready = 1'b0;

  logic [2:0]  current_state;
  logic        pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]  wb_sel, alu_src_b, alu_op;
  logic        alu_src_a, is_halted;
  logic [31:0] cycle_cnt, instret_cnt;

  logic [2:0]  w4_state;
  logic        w4_pcw, w4_pcs, w4_iod, w4_mrd, w4_mwr, w4_irw, w4_rgw, w4_asa, w4_halted;
  logic [1:0]  w4_wbs, w4_asb, w4_aop;
  logic [3:0]  w4_cycle_cnt, w4_instret_cnt;

  mc_control_unit #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .next_state(next_state),
    .bcond(bcond), .halt_req(halt_req), .mem_ready(mem_ready),
    .current_state(current_state), .pc_write(pc_write), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  mc_control_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .next_state(next_state),
    .bcond(bcond), .halt_req(halt_req), .mem_ready(mem_ready),
    .current_state(w4_state), .pc_write(w4_pcw), .pc_source(w4_pcs),
    .i_or_d(w4_iod), .mem_read(w4_mrd), .mem_write(w4_mwr), .ir_write(w4_irw),
    .reg_write(w4_rgw), .wb_sel(w4_wbs), .alu_src_a(w4_asa),
    .alu_src_b(w4_asb), .alu_op(w4_aop), .is_halted(w4_halted),
    .cycle_cnt(w4_cycle_cnt), .instret_cnt(w4_instret_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0]  m_state;
  logic        m_halt;
  logic [31:0] m_cyc, m_ins;
  logic [6:0]  cur_op;
  logic [31:0] t_start, n_stall;
  logic        taken;
  logic        allow_halt = 1'b0;
  logic [31:0] exp_q[$];   // expected cycle_cnt at each retirement
  logic [6:0]  op_tab[8];

  task automatic model_reset();
    m_state = 3'd0; m_halt = 1'b0; m_cyc = '0; m_ins = '0;
    cur_op = OP_ARITH; t_start = '0; n_stall = '0; taken = 1'b0;
    exp_q.delete();
  endtask

  // Instruction flow of the external fsm.
  function automatic logic [2:0] fsm_next(input logic [2:0] st, input logic [6:0] op, input logic bc);
    case (st)
      S_IF1:   return S_IF2;
      S_IF2:   return (op == OP_ECALL) ? S_IF1 : S_ID;
      S_ID:    return (op == OP_JAL) ? S_WB : S_EX;
      S_EX:    return (op == OP_LOAD) ? S_MEM :
                      (op == OP_BRANCH && !bc) ? S_IF1 : S_WB;
      S_MEM:   return S_WB;
      default: return S_IF1;
    endcase
  endfunction

  function automatic int base_cycles(input logic [6:0] op, input logic tk);
    case (op)
      OP_LOAD:   return 6;
      OP_JAL:    return 4;
      OP_BRANCH: return tk ? 5 : 4;
      OP_ECALL:  return 2;
      default:   return 5;
    endcase
  endfunction

  // Expected strobes, packed {pcw,pcs,iod,mrd,mwr,irw,rgw,wbs,asa,asb,aop}.
  function automatic logic [13:0] exp_strobes(input logic [2:0] st, input logic [6:0] op,
                                              input logic bc, input logic mr, input logic hr,
                                              input logic active);
    logic pcw, pcs, iod, mrd, mwr, irw, rgw, asa;
    logic [1:0] wbs, asb, aop;
    {pcw, pcs, iod, mrd, mwr, irw, rgw, asa} = '0;
    wbs = 2'd0; asb = 2'd0; aop = 2'd0;
    if (active) begin
      if (st == S_IF1) mrd = 1'b1;
      else if (st == S_IF2) begin
        mrd = 1'b1; irw = mr; asb = 2'd1;
        if (op == OP_ECALL && !hr) pcw = mr;
      end
      else if (st == S_ID) asb = 2'd2;
      else if (st == S_EX) begin
        asa = (op == OP_ARITH) || (op == OP_ARITH_IMM) || (op == OP_LOAD) ||
              (op == OP_STORE) || (op == OP_JALR) || (op == OP_BRANCH);
        asb = ((op == OP_ARITH_IMM) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_JALR) || (op == OP_JAL)) ? 2'd2 : 2'd0;
        aop = ((op == OP_ARITH) || (op == OP_ARITH_IMM)) ? 2'd2 :
              (op == OP_BRANCH) ? 2'd1 : 2'd0;
        if (op == OP_BRANCH && !bc) pcw = 1'b1;
      end
      else if (st == S_MEM) begin mrd = 1'b1; iod = 1'b1; end
      else if (st == S_WB) begin
        pcw = (op == OP_STORE) ? mr : 1'b1;
        pcs = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
        rgw = (op == OP_ARITH) || (op == OP_ARITH_IMM) || (op == OP_LOAD) ||
              (op == OP_JAL) || (op == OP_JALR);
        wbs = (op == OP_LOAD) ? 2'd1 : ((op == OP_JAL) || (op == OP_JALR)) ? 2'd2 : 2'd0;
        if (op == OP_STORE) begin mwr = 1'b1; iod = 1'b1; end
      end
    end
    return {pcw, pcs, iod, mrd, mwr, irw, rgw, wbs, asa, asb, aop};
  endfunction

  function automatic logic [13:0] dut_strobes();
    return {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
            wb_sel, alu_src_a, alu_src_b, alu_op};
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic mr, input logic bc, input logic hr, input logic [6:0] new_op);
    logic stall, halt_now, hr_eff;
    logic [2:0] nxt;
    @(negedge clk);
    if (!m_halt && m_state == S_IF1) begin
      cur_op = new_op; t_start = m_cyc; n_stall = '0; taken = 1'b0;
    end
    hr_eff     = hr && (allow_halt || cur_op != OP_ECALL);
    opcode     = cur_op;
    mem_ready  = mr;
    bcond      = bc;
    halt_req   = hr_eff;
    next_state = fsm_next(m_state, cur_op, bc);
    #1;
    check_eq("state",   32'(current_state), 32'(m_state));
    check_eq("halted",  32'(is_halted), 32'(m_halt));
    check_eq("cycle",   cycle_cnt, m_cyc);
    check_eq("instret", instret_cnt, m_ins);
    check_eq("strobes", 32'(dut_strobes()),
             32'(exp_strobes(m_state, cur_op, bc, mr, hr_eff, !m_halt)));
    check_eq("cycle4",   32'(w4_cycle_cnt), 32'(m_cyc[3:0]));
    check_eq("instret4", 32'(w4_instret_cnt), 32'(m_ins[3:0]));
    if (exp_q.size() > 0) check_eq("latency", cycle_cnt, exp_q.pop_front());
    if (!m_halt) begin
      stall    = ((m_state == S_IF2) || (m_state == S_MEM) ||
                  (m_state == S_WB && cur_op == OP_STORE)) && !mr;
      halt_now = (m_state == S_IF2) && (cur_op == OP_ECALL) && hr_eff && mr;
      m_cyc    = m_cyc + 32'd1;
      if (m_state == S_EX && cur_op == OP_BRANCH) taken = bc;
      if (stall) begin
        n_stall = n_stall + 32'd1;
      end else begin
        nxt = halt_now ? 3'(S_IF1) : fsm_next(m_state, cur_op, bc);
        if (nxt == S_IF1 && m_state != S_IF1 && m_state != S_ID) begin
          m_ins = m_ins + 32'd1;
          exp_q.push_back(t_start + 32'(base_cycles(cur_op, taken)) + n_stall);
        end
        m_state = nxt;
        m_halt  = halt_now;
      end
    end
  endtask

  task automatic release_reset();
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] t0;
    int k;
    op_tab[0] = OP_ARITH;  op_tab[1] = OP_ARITH_IMM; op_tab[2] = OP_LOAD;
    op_tab[3] = OP_STORE;  op_tab[4] = OP_BRANCH;    op_tab[5] = OP_JAL;
    op_tab[6] = OP_JALR;   op_tab[7] = OP_ECALL;

    // Reset state with memory ready and fetch-looking inputs.
    mem_ready = 1'b1;
    #2;
    check_eq("rst_state",   32'(current_state), 32'd0);
    check_eq("rst_strobes", 32'(dut_strobes()), 32'd0);
    check_eq("rst_cycle",   cycle_cnt, 32'd0);
    release_reset();

    // ADD, no stalls: IF1 IF2 ID EX WB.
    repeat (5) step(1'b1, 1'b0, 1'b0, OP_ARITH);

    // LOAD with 3 stall cycles in MEM: 9 cycles total.
    t0 = m_cyc; k = 0;
    for (int i = 0; i < 20 && !(i > 0 && m_state == S_IF1); i++) begin
      if (m_state == S_MEM && k < 3) begin
        k++; step(1'b0, 1'b0, 1'b0, OP_LOAD);
      end else begin
        step(1'b1, 1'b0, 1'b0, OP_LOAD);
      end
    end
    @(posedge clk); #1;
    check_eq("load_latency", cycle_cnt - t0, 32'd9);

    // BEQ not taken then taken.
    repeat (4) step(1'b1, 1'b0, 1'b0, OP_BRANCH);
    repeat (5) step(1'b1, 1'b1, 1'b0, OP_BRANCH);

    // Randomized instruction stream.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), op_tab[3'($urandom_range(0, 7))]);
    end

    // Asynchronous reset in the middle of EX.
    for (int i = 0; i < 10 && m_state != S_EX; i++) step(1'b1, 1'b0, 1'b0, OP_ARITH);
    @(negedge clk);
    next_state = 3'(S_WB);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("midex_state",   32'(current_state), 32'd0);
    check_eq("midex_cycle",   cycle_cnt, 32'd0);
    check_eq("midex_instret", instret_cnt, 32'd0);
    check_eq("midex_strobes", 32'(dut_strobes()), 32'd0);
    release_reset();

    // Narrow counter wrap: 15 edges, then one more wraps to 0.
    repeat (15) step(1'b1, 1'b0, 1'b0, OP_ARITH);
    @(posedge clk); #1;
    check_eq("wrap_pre", 32'(w4_cycle_cnt), 32'd15);
    step(1'b1, 1'b0, 1'b0, OP_ARITH);
    @(posedge clk); #1;
    check_eq("wrap_zero", 32'(w4_cycle_cnt), 32'd0);

    // Finish the current instruction, then halting ECALL with a stalled fetch.
    for (int i = 0; i < 10 && m_state != S_IF1; i++) step(1'b1, 1'b0, 1'b0, OP_ARITH);
    allow_halt = 1'b1;
    step(1'b1, 1'b0, 1'b1, OP_ECALL);
    step(1'b0, 1'b0, 1'b1, OP_ECALL);
    step(1'b0, 1'b0, 1'b1, OP_ECALL);
    step(1'b1, 1'b0, 1'b1, OP_ECALL);
    @(posedge clk); #1;
    check_eq("halt_flag", 32'(is_halted), 32'd1);
    t0 = cycle_cnt;
    repeat (10) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), op_tab[3'($urandom_range(0, 7))]);
    @(posedge clk); #1;
    check_eq("halt_frozen", cycle_cnt, t0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle RV32I control unit. Holds the 3-bit state register, takes the next-state value from the `fsm` next-state block, and stalls on a memory handshake. Decodes every datapath control strobe from the registered state and the current opcode, tracks ECALL halt, and counts cycles and retired instructions. Sits between `fsm` (its next-state source) and the datapath/memory (consumers of its strobes).

## Interface
Parameters:
- `CNT_W`, default 32: width of `cycle_cnt` and `instret_cnt`.

Ports:
- `clk`, input, 1: single clock. All state changes happen on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `opcode`, input, 7: instruction opcode. Valid from IF2 onward: driven from memory read data in IF2 and from the IR afterwards.
- `next_state`, input, 3: next state from `fsm`.
- `bcond`, input, 1: branch condition from the ALU, valid in EX.
- `halt_req`, input, 1: x17 == 10, sampled in IF2.
- `mem_ready`, input, 1: memory completes the current access this cycle.
- `current_state`, output, 3: registered state, fed back to `fsm`.
- `pc_write`, output, 1: PC write strobe.
- `pc_source`, output, 1: PC source select. 0 = PC+4 register, 1 = ALUOut.
- `i_or_d`, output, 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, output, 1: memory read strobe.
- `mem_write`, output, 1: memory write strobe.
- `ir_write`, output, 1: IR write strobe.
- `reg_write`, output, 1: register-file write strobe.
- `wb_sel`, output, 2: write-back select. 0 = ALUOut, 1 = MDR, 2 = PC+4.
- `alu_src_a`, output, 1: ALU A select. 0 = PC, 1 = register A.
- `alu_src_b`, output, 2: ALU B select. 0 = register B, 1 = 4, 2 = immediate.
- `alu_op`, output, 2: ALU op class. 0 = ADD, 1 = BRANCH compare, 2 = FUNCT.
- `is_halted`, output, 1: sticky halt flag.
- `cycle_cnt`, output, CNT_W: cycles since reset while not halted.
- `instret_cnt`, output, CNT_W: retired instructions.

## Operation
State transitions:
- State codes come from `states.v`: IF1, IF2, ID, EX, MEM, WB. Reset state is IF1.
- Each rising edge, `current_state <= next_state` unless the unit is stalled or halted.
- Memory-access states are IF2 (fetch), MEM (load) and WB when the opcode is STORE.
- Stall condition: current state is a memory-access state and `mem_ready` = 0. While stalled, state holds and all strobes stay asserted.
- Halt: in IF2 with opcode = ECALL, `halt_req` = 1 and `mem_ready` = 1, `is_halted` is set and the state goes to IF1. From then on, state is frozen at IF1, all strobes are 0 and counters freeze until reset.

Control decode (unlisted strobes are 0):
- IF1: `mem_read` = 1, `i_or_d` = 0.
- IF2: `mem_read` = 1, `ir_write` = `mem_ready`, ALU computes PC + 4 (`alu_src_a` = 0, `alu_src_b` = 1, ADD). For an ECALL that is not halting, also `pc_write` = `mem_ready` with `pc_source` = 0.
- ID: ALU computes PC + imm (`alu_src_a` = 0, `alu_src_b` = 2, ADD).
- EX by opcode:
  - ARITHMETIC: A op B, FUNCT.
  - ARITHMETIC_IMM, LOAD, STORE, JALR: A + imm. ARITHMETIC_IMM uses FUNCT; the others use ADD.
  - JAL: PC + imm, ADD.
  - BRANCH: A vs B, BRANCH compare. If `bcond` = 0, also `pc_write` = 1 with `pc_source` = 0.
- MEM: `mem_read` = 1, `i_or_d` = 1.
- WB:
  - `pc_write` = 1 for every opcode. (If stalled on a store, it is asserted only in the completing cycle.)
  - `pc_source` = 1 for a taken BRANCH, JAL or JALR; otherwise 0.
  - `reg_write` = 1 for ARITHMETIC and ARITHMETIC_IMM (`wb_sel` = 0), LOAD (`wb_sel` = 1), and JAL/JALR (`wb_sel` = 2).
  - STORE: `mem_write` = 1, `i_or_d` = 1.
- JAL and JALR targets need ALUOut to hold the target at WB. The datapath latches PC+4 at IF2.

Counters:
- `instret_cnt` increments on every edge that takes the state into IF1 from IF2, EX, MEM or WB. This includes the halting ECALL.
- `cycle_cnt` increments on every edge while `is_halted` = 0.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset (asynchronous, any state, including mid-stall): `current_state` = IF1; `is_halted`, both counters and every strobe are 0.
- First fetch: `mem_read` = 1 in the first cycle after `reset_n` rises.
- Strobes are combinational from `current_state`, `opcode`, `bcond` and `mem_ready`. They have zero latency and no registered outputs except state, counters and halt.
- Minimum instruction latency with `mem_ready` tied to 1:
  - R-type and ALU-immediate: 5 cycles.
  - Load: 6 cycles.
  - Store: 5 cycles.
  - Branch not taken: 4 cycles.
  - JAL: 4 cycles.
- Each stall cycle adds 1 cycle.
- If `mem_ready` arrives in the same cycle as a halting ECALL, the halt takes priority.

## Structure
- Existing shared headers: `states.v` (state codes) and `opcodes.v` (opcodes).
- New shared header `ctrl_defs.v`: encodings for `alu_op`, `alu_src_b`, `wb_sel` and `pc_source`.
- One sub-module, `mc_ctrl_decode`: purely combinational strobe decode.
- The top level holds the state register, the stall/halt logic and the counters.

## Test plan
- Reset with `reset_n` = 0 mid-EX → `current_state` = IF1 within the same cycle, counters 0, all strobes 0.
- ADD with `mem_ready` = 1 → states IF1, IF2, ID, EX, WB; `reg_write` = 1 and `wb_sel` = 0 in WB only; `instret_cnt` 0→1 after 5 cycles.
- LOAD with `mem_ready` low for 3 cycles in MEM → state holds MEM for 4 cycles with `mem_read` = 1 and `i_or_d` = 1; `cycle_cnt` = 9 at retire.
- BEQ with `bcond` = 0 → EX asserts `pc_write` = 1, `pc_source` = 0, next state IF1. With `bcond` = 1 → WB asserts `pc_source` = 1.
- ECALL with `halt_req` = 1 → `is_halted` = 1 after the IF2 edge; counters freeze; 10 further cycles show no strobes.
- Preload `cycle_cnt` near 2^CNT_W − 1 (CNT_W = 4 build) → wraps to 0 on the next edge.
